// File: rtl/table_ad_receive_pkg.sv
// Shared table address/data link definitions, used by both the transmitter and the receiver.
package table_ad_receive_pkg;

  localparam int unsigned ADDR_BYTES = 3;
  localparam int unsigned DATA_BYTES = 4;

  typedef enum logic {
    BURST_DATA = 1'b0,
    BURST_ADDR = 1'b1
  } burst_t;

  function automatic bit dw_legal(input int unsigned dw);
    return (dw == 8) || (dw == 16) || (dw == 32);
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/table_ad_receive_if.sv
// Byte-serial link input and table write port for one receiver channel.
interface table_ad_receive_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10
);
  logic [7:0]            ser_d;
  logic                  a_not_d;
  logic                  chn_en;
  logic [ADDR_BITS-1:0]  taddr;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  twe;

  modport master (output ser_d, a_not_d, chn_en, input taddr, tdata, twe);
  modport slave  (input ser_d, a_not_d, chn_en, output taddr, tdata, twe);
endinterface

// File: rtl/table_ad_byte_cnt.sv
// Burst byte counter: saturates after the expected byte count, latches burst type,
// and flags the byte that completes each table-word lane.
module table_ad_byte_cnt
  import table_ad_receive_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       i_chn_en,
  input  logic       i_a_not_d,
  output logic       o_vld,
  output logic       o_first,
  output logic       o_is_addr,
  output logic       o_lane_done,
  output logic [1:0] o_cnt
);
  localparam logic [1:0] LANE_MASK = 2'(bytes_per_word(DATA_WIDTH) - 1);

  logic [1:0] r_cnt;
  logic       r_sat;
  logic       r_blk;
  burst_t     r_type;

  logic       w_vld;
  logic       w_first;
  burst_t     w_type;
  logic [1:0] w_last_idx;

  always_comb begin
    w_vld      = i_chn_en && !r_sat && !r_blk;
    w_first    = w_vld && (r_cnt == '0);
    w_type     = w_first ? (i_a_not_d ? BURST_ADDR : BURST_DATA) : r_type;
    w_last_idx = (w_type == BURST_ADDR) ? 2'(ADDR_BYTES - 1) : 2'(DATA_BYTES - 1);
  end

  // A reset landing inside a burst blocks the rest of it until chn_en drops.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_blk  <= i_chn_en;
      r_type <= BURST_DATA;
    end else if (!i_chn_en) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_blk <= 1'b0;
    end else if (w_vld) begin
      r_type <= w_type;
      if (r_cnt == w_last_idx) r_sat <= 1'b1;
      else                     r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_vld       = w_vld;
  assign o_first     = w_first;
  assign o_is_addr   = (w_type == BURST_ADDR);
  assign o_lane_done = w_vld && (w_type == BURST_DATA) && ((r_cnt & LANE_MASK) == LANE_MASK);
  assign o_cnt       = r_cnt;

endmodule

// File: rtl/table_ad_receive.sv
// Per-channel table address/data receiver: rebuilds addresses and data words from
// the byte-serial link and drives an auto-incrementing table write port.
module table_ad_receive
  import table_ad_receive_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10
) (
  input logic               clk,
  input logic               srst,
  table_ad_receive_if.slave bus
);
  localparam int unsigned HOLD_W = 8 * ADDR_BYTES;

  logic                  w_vld;
  logic                  w_first;
  logic                  w_is_addr;
  logic                  w_lane_done;
  logic [1:0]            w_cnt;
  logic [31:0]           w_shift_nx;

  logic [ADDR_BITS-1:0]  r_taddr;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_twe;
  logic [HOLD_W-1:0]     r_hold;
  logic [23:0]           r_shift;
  logic                  r_apend;

  table_ad_byte_cnt #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
    .clk        (clk),
    .srst       (srst),
    .i_chn_en   (bus.chn_en),
    .i_a_not_d  (bus.a_not_d),
    .o_vld      (w_vld),
    .o_first    (w_first),
    .o_is_addr  (w_is_addr),
    .o_lane_done(w_lane_done),
    .o_cnt      (w_cnt)
  );

  // Newest byte enters at the top, so the completed word is always the top DATA_WIDTH bits.
  assign w_shift_nx = {bus.ser_d, r_shift};

  always_ff @(posedge clk) begin
    if (srst) begin
      r_taddr <= '0;
      r_tdata <= '0;
      r_twe   <= 1'b0;
      r_hold  <= '0;
      r_shift <= '0;
      r_apend <= 1'b0;
    end else begin
      r_twe <= w_lane_done;
      if (w_lane_done) r_tdata <= DATA_WIDTH'(w_shift_nx >> (32 - DATA_WIDTH));
      if (w_vld && !w_is_addr) r_shift <= w_shift_nx[31:8];
      if (w_vld && w_is_addr) begin
        r_apend <= 1'b1;
        if (w_first) r_hold <= HOLD_W'(bus.ser_d);
        else begin
          case (w_cnt)
            2'd1:    r_hold[15:8]  <= bus.ser_d;
            2'd2:    r_hold[23:16] <= bus.ser_d;
            default: ;
          endcase
        end
      end
      // Address commit takes priority over a post-write increment.
      if (r_apend && !bus.chn_en) begin
        r_taddr <= ADDR_BITS'(r_hold);
        r_apend <= 1'b0;
      end else if (r_twe) begin
        r_taddr <= r_taddr + ADDR_BITS'(1);
      end
    end
  end

  assign bus.taddr = r_taddr;
  assign bus.tdata = r_tdata;
  assign bus.twe   = r_twe;

endmodule

// File: tb/tb_table_ad_receive.sv
// Directed bench: three receivers (DATA_WIDTH 8/16/32, ADDR_BITS 10) share one link stimulus.
module tb_table_ad_receive;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [7:0] ser_d = '0;
  logic       a_not_d = 1'b0;
  logic       chn_en = 1'b0;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  table_ad_receive_if #(.DATA_WIDTH(8),  .ADDR_BITS(10)) b8 ();
  table_ad_receive_if #(.DATA_WIDTH(16), .ADDR_BITS(10)) b16 ();
  table_ad_receive_if #(.DATA_WIDTH(32), .ADDR_BITS(10)) b32 ();

  assign b8.ser_d  = ser_d;  assign b8.a_not_d  = a_not_d;  assign b8.chn_en  = chn_en;
  assign b16.ser_d = ser_d;  assign b16.a_not_d = a_not_d;  assign b16.chn_en = chn_en;
  assign b32.ser_d = ser_d;  assign b32.a_not_d = a_not_d;  assign b32.chn_en = chn_en;

  table_ad_receive #(.DATA_WIDTH(8),  .ADDR_BITS(10)) u8  (.clk(clk), .srst(srst), .bus(b8));
  table_ad_receive #(.DATA_WIDTH(16), .ADDR_BITS(10)) u16 (.clk(clk), .srst(srst), .bus(b16));
  table_ad_receive #(.DATA_WIDTH(32), .ADDR_BITS(10)) u32 (.clk(clk), .srst(srst), .bus(b32));

  typedef struct {
    int unsigned cyc;
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t q8[$];
  wr_t q16[$];
  wr_t q32[$];

  always @(negedge clk) begin
    if (b8.twe === 1'b1)  q8.push_back('{cyc, 16'(b8.taddr), 32'(b8.tdata)});
    if (b16.twe === 1'b1) q16.push_back('{cyc, 16'(b16.taddr), 32'(b16.tdata)});
    if (b32.twe === 1'b1) q32.push_back('{cyc, 16'(b32.taddr), 32'(b32.tdata)});
  end

  int n_assert = 0;
  int n_fail = 0;
  int unsigned t_samp;
  int unsigned t0;
  int unsigned t1;
  wr_t w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic wr_t get_wr(input int wd, input int i);
    wr_t e;
    e.cyc = 0;
    e.a = 'x;
    e.d = 'x;
    case (wd)
      8:  if (i < q8.size())  e = q8[i];
      16: if (i < q16.size()) e = q16[i];
      default: if (i < q32.size()) e = q32[i];
    endcase
    return e;
  endfunction

  task automatic exp_n(input string tag, input int wd, input int n);
    int sz;
    case (wd)
      8:  sz = q8.size();
      16: sz = q16.size();
      default: sz = q32.size();
    endcase
    chk($sformatf("%s dw%0d nwrites", tag, wd), 32'(sz), 32'(n));
  endtask

  task automatic exp_wr(input string tag, input int wd, input int i,
                        input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e = get_wr(wd, i);
    chk($sformatf("%s dw%0d wr%0d taddr", tag, wd, i), 32'(e.a), 32'(a));
    chk($sformatf("%s dw%0d wr%0d tdata", tag, wd, i), e.d, d);
  endtask

  task automatic chk_taddr(input string tag, input logic [9:0] e8, input logic [9:0] e16,
                           input logic [9:0] e32);
    chk({tag, " dw8 taddr"},  32'(b8.taddr),  32'(e8));
    chk({tag, " dw16 taddr"}, 32'(b16.taddr), 32'(e16));
    chk({tag, " dw32 taddr"}, 32'(b32.taddr), 32'(e32));
  endtask

  task automatic chk_zero(input string tag);
    chk_taddr(tag, 10'h0, 10'h0, 10'h0);
    chk({tag, " dw8 tdata"},  32'(b8.tdata),  32'h0);
    chk({tag, " dw16 tdata"}, 32'(b16.tdata), 32'h0);
    chk({tag, " dw32 tdata"}, 32'(b32.tdata), 32'h0);
    chk({tag, " twe"}, {29'h0, b8.twe, b16.twe, b32.twe}, 32'h0);
  endtask

  task automatic clear_q();
    q8.delete();
    q16.delete();
    q32.delete();
  endtask

  task automatic send(input logic a, input logic [7:0] b, input logic rst = 1'b0);
    @(negedge clk);
    srst = rst;
    chn_en = 1'b1;
    a_not_d = a;
    ser_d = b;
    t_samp = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      srst = 1'b0;
      chn_en = 1'b0;
      a_not_d = 1'b0;
      ser_d = '0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    idle(2);
    clear_q();

    // Address 0x053412 -> 0x012, then 0xDEADBEEF
    send(1, 8'h12); send(1, 8'h34); send(1, 8'h05);
    idle(2);
    chk_taddr("s1 commit", 10'h012, 10'h012, 10'h012);
    send(0, 8'hEF); send(0, 8'hBE); send(0, 8'hAD); send(0, 8'hDE);
    t1 = t_samp;
    idle(3);
    exp_n("s1", 32, 1);
    exp_wr("s1", 32, 0, 16'h012, 32'hDEADBEEF);
    w = get_wr(32, 0);
    chk("s1 dw32 twe latency", w.cyc, t1);
    exp_n("s1", 16, 2);
    exp_wr("s1", 16, 0, 16'h012, 32'h0000BEEF);
    exp_wr("s1", 16, 1, 16'h013, 32'h0000DEAD);
    exp_n("s1", 8, 4);
    exp_wr("s1", 8, 0, 16'h012, 32'h000000EF);
    exp_wr("s1", 8, 3, 16'h015, 32'h000000DE);
    chk_taddr("s1 inc", 10'h016, 10'h014, 10'h013);
    clear_q();

    // Address 0x10, then 0x44332211: byte-wide writes on consecutive cycles
    send(1, 8'h10); send(1, 8'h00); send(1, 8'h00);
    idle(2);
    send(0, 8'h11);
    t0 = t_samp;
    send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
    idle(3);
    exp_n("s2", 8, 4);
    for (int i = 0; i < 4; i++) begin
      exp_wr("s2", 8, i, 16'(16'h010 + i), 32'(8'h11 * (i + 1)));
      w = get_wr(8, i);
      chk($sformatf("s2 dw8 wr%0d cycle", i), w.cyc, t0 + 32'(i));
    end
    exp_n("s2", 16, 2);
    exp_wr("s2", 16, 0, 16'h010, 32'h00002211);
    exp_wr("s2", 16, 1, 16'h011, 32'h00004433);
    exp_n("s2", 32, 1);
    exp_wr("s2", 32, 0, 16'h010, 32'h44332211);
    chk_taddr("s2 inc", 10'h014, 10'h012, 10'h011);
    clear_q();

    // Address 0x3FF, two data bursts one idle apart, address wraps
    send(1, 8'hFF); send(1, 8'h03); send(1, 8'h00);
    idle(2);
    send(0, 8'hAA); send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hBB);
    idle(1);
    send(0, 8'hCC); send(0, 8'hCC); send(0, 8'hDD); send(0, 8'hDD);
    idle(3);
    exp_n("s3", 16, 4);
    exp_wr("s3", 16, 0, 16'h3FF, 32'h0000AAAA);
    exp_wr("s3", 16, 1, 16'h000, 32'h0000BBBB);
    exp_wr("s3", 16, 2, 16'h001, 32'h0000CCCC);
    exp_wr("s3", 16, 3, 16'h002, 32'h0000DDDD);
    exp_n("s3", 32, 2);
    exp_wr("s3", 32, 0, 16'h3FF, 32'hBBBBAAAA);
    exp_wr("s3", 32, 1, 16'h000, 32'hDDDDCCCC);
    exp_n("s3", 8, 8);
    exp_wr("s3", 8, 7, 16'h006, 32'h000000DD);
    chk_taddr("s3 wrap", 10'h007, 10'h003, 10'h001);
    clear_q();

    // Truncated data burst, then truncated address burst
    send(0, 8'h11); send(0, 8'h22);
    idle(3);
    exp_n("s4", 32, 0);
    exp_n("s4", 16, 1);
    exp_wr("s4", 16, 0, 16'h003, 32'h00002211);
    exp_n("s4", 8, 2);
    exp_wr("s4", 8, 1, 16'h008, 32'h00000022);
    chk_taddr("s4 trunc data", 10'h009, 10'h004, 10'h001);
    clear_q();
    send(1, 8'h21); send(1, 8'h43);
    idle(2);
    chk_taddr("s4 trunc addr", 10'h321, 10'h321, 10'h321);

    // Overlong data burst: bytes beyond four are ignored
    for (int i = 1; i <= 6; i++) send(0, 8'(i));
    idle(3);
    exp_n("s5", 32, 1);
    exp_wr("s5", 32, 0, 16'h321, 32'h04030201);
    exp_n("s5", 16, 2);
    exp_wr("s5", 16, 1, 16'h322, 32'h00000403);
    exp_n("s5", 8, 4);
    exp_wr("s5", 8, 3, 16'h324, 32'h00000004);
    chk_taddr("s5 overlong", 10'h325, 10'h323, 10'h322);
    clear_q();

    // Reset on byte 2 of a data burst; remainder of burst is ignored
    send(0, 8'hA1); send(0, 8'hA2);
    send(0, 8'hA3, 1'b1);
    send(0, 8'hA4);
    chk_zero("s6 after srst");
    idle(3);
    exp_n("s6", 32, 0);
    exp_n("s6", 16, 1);
    exp_wr("s6", 16, 0, 16'h323, 32'h0000A2A1);
    exp_n("s6", 8, 2);
    exp_wr("s6", 8, 1, 16'h326, 32'h000000A2);
    chk_taddr("s6 blocked", 10'h000, 10'h000, 10'h000);
    clear_q();

    // Next burst after the reset is received normally
    send(0, 8'h55); send(0, 8'h66); send(0, 8'h77); send(0, 8'h88);
    idle(3);
    exp_n("s7", 32, 1);
    exp_wr("s7", 32, 0, 16'h000, 32'h88776655);
    chk_taddr("s7 resume", 10'h004, 10'h002, 10'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/table_ad_receive.md
# table_ad_receive

Per-channel receiver for the byte-serial table address/data link. It consumes the 8-bit serial bytes, address/data flag and one channel-enable bit produced by the table transmitter on the command path. It reassembles 24-bit start addresses and 32-bit data words, then drives a single-port table write interface (address, data, write strobe) inside the submodule that owns the table. After every write the address auto-increments, so one address command is followed by any number of data commands.

## Interface
Parameters:
- DATA_WIDTH, 32, table word width; legal values 8, 16, 32; each 32-bit data burst yields 32/DATA_WIDTH writes.
- ADDR_BITS, 10, table address width (1..24); the low ADDR_BITS of the 24-bit received address are used, in table-word units.

Ports:
- clk, input, 1, system clock (posedge mclk); single clock domain.
- srst, input, 1, synchronous active-high reset.
- ser_d, input, 8, serial byte, LSB byte first.
- a_not_d, input, 1, 1 = current burst carries an address, 0 = data; constant during a burst.
- chn_en, input, 1, this channel's enable bit; high for every byte of a burst.
- taddr, output, ADDR_BITS, table write address.
- tdata, output, DATA_WIDTH, table write data.
- twe, output, 1, table write strobe, one cycle per word.

## Operation
- Burst: a maximal run of cycles with chn_en=1. The link guarantees at least 1 idle cycle between bursts.
- A 2-bit byte counter plus a saturate flag counts valid bytes.
  - The counter clears on any cycle with chn_en=0 and on srst.
  - Bytes beyond the expected count are ignored: address burst 3 bytes, data burst 4 bytes.
- Burst type is latched on the first byte (counter=0). a_not_d on later bytes is ignored.
- Address burst:
  - Bytes 0..2 are shifted into a 24-bit holding register; bytes not received remain 0.
  - The holding register is zeroed at the first byte of an address burst.
  - Commit happens on the first cycle chn_en=0 after the burst: taddr <= hold[ADDR_BITS-1:0].
  - Bits above ADDR_BITS are discarded.
- Data burst:
  - Bytes accumulate into a 32-bit shift register, LSB byte first.
  - When DATA_WIDTH/8 bytes of the current lane group have arrived, the word is registered to tdata and twe pulses.
  - DATA_WIDTH=8: writes after bytes 0,1,2,3. DATA_WIDTH=16: writes after bytes 1,3. DATA_WIDTH=32: one write after byte 3.
- Address increment: taddr <= taddr+1 on the cycle after each twe. It wraps modulo 2^ADDR_BITS with no flag.
- Truncated data burst (chn_en drops early): an incomplete word is discarded. Words already written stay written, and taddr reflects those writes only.
- An address commit and a twe can never coincide, because of the mandatory idle gap. If they ever did, the address commit would win and the increment would be dropped.
- srst mid-burst: all state clears immediately. The remainder of that burst is treated as a new burst only after chn_en goes low.

## Timing
- Reset values: taddr=0, tdata=0, twe=0, counter=0, hold register=0.
- twe latency: asserted exactly 1 cycle after the clock edge sampling the byte that completes the word. tdata is valid in the same cycle as twe and holds until the next write.
- taddr is stable during twe and changes only on the following cycle.
- Address commit latency: taddr is updated at the end of the first idle cycle after the address burst.
- With the transmitter timing (address bytes T+2..T+4, next data bytes at ≥T+7), the committed address is valid before the first data byte.
- Back-to-back data bursts separated by 1 idle cycle must be supported without losing writes.
- Throughput: at most one write per cycle (DATA_WIDTH=8).

## Structure
- A shared link package holds:
  - link constants: ADDR_BYTES=3, DATA_BYTES=4;
  - legal DATA_WIDTH set;
  - a function giving bytes-per-word = DATA_WIDTH/8.
- The package is shared with the transmitter.
- One sub-module is natural: table_ad_byte_cnt (burst byte counter with saturate flag, first-byte and last-byte-of-lane decode).
- Everything else is flat registers in table_ad_receive.

## Test plan
- DATA_WIDTH=32, ADDR_BITS=10:
  - stimulus: address burst 0x12,0x34,0x05, then data burst 0xEF,0xBE,0xAD,0xDE;
  - required: one twe with taddr=0x012 (0x053412 & 0x3FF) and tdata=0xDEADBEEF, then taddr=0x013.
- DATA_WIDTH=8:
  - stimulus: address 0x000010, then data 0x44332211;
  - required: four consecutive twe at taddr 0x10..0x13 with tdata 0x11,0x22,0x33,0x44; taddr=0x14 after.
- DATA_WIDTH=16:
  - stimulus: address 0x3FF (ADDR_BITS=10), then two data bursts 0xBBBBAAAA, 0xDDDDCCCC with 1 idle cycle between;
  - required: writes 0x3FF:0xAAAA, 0x000:0xBBBB, 0x001:0xCCCC, 0x002:0xDDDD (wrap).
- Truncation:
  - stimulus: data burst of 2 bytes in DATA_WIDTH=32;
  - required: no twe, taddr unchanged.
  - stimulus: 2-byte address burst 0x21,0x43;
  - required: taddr=0x4321 masked to ADDR_BITS.
- Overlong / reset:
  - stimulus: data burst of 6 bytes;
  - required: one write of bytes 0..3, bytes 4..5 ignored.
  - stimulus: srst asserted on byte 2 of a data burst;
  - required: all outputs 0 next cycle and no twe for that burst.
